// File: rtl/wb_sequencer.sv
// Register-file write sequencer: merges single-cycle ALU results with valid/ready
// multiply/divide results through a 2-entry in-order FIFO onto one registered write port.
module wb_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        alu_valid,
  input  logic [3:0]  alu_dest,
  input  logic [15:0] alu_result,
  output logic        alu_stall,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [3:0]  md_dest,
  input  logic [31:0] md_result,
  output logic        write_en,
  output logic        R0_en,
  output logic [3:0]  write_address,
  output logic [31:0] write_data,
  output logic [1:0]  buf_count
);

  typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} state_e;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d, tail_q, tail_d;
  entry_t md_entry;

  logic        we_q, r0_q;
  logic [3:0]  waddr_q;
  logic [31:0] wdata_q;

  logic        issue, iss_r0, deq, enq, bypass, md_xfer;
  logic [3:0]  iss_addr;
  logic [31:0] iss_data;

  assign md_ready  = !rst && !halt_sys && (state_q != StFull);
  assign alu_stall = alu_valid && (rst || halt_sys || (state_q == StFull));
  assign md_xfer   = md_valid && md_ready;
  assign md_entry  = '{dest: md_dest, data: md_result};
  assign buf_count = state_q;

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    issue    = 1'b0;
    iss_r0   = 1'b0;
    iss_addr = waddr_q;
    iss_data = wdata_q;
    deq      = 1'b0;
    bypass   = 1'b0;
    enq      = 1'b0;

    if (!halt_sys) begin
      if (state_q == StFull) begin
        issue = 1'b1;
        deq   = 1'b1;
      end else if (alu_valid) begin
        issue    = 1'b1;
        iss_addr = alu_dest;
        iss_data = {16'h0000, alu_result};
      end else if (state_q == StOne) begin
        issue = 1'b1;
        deq   = 1'b1;
      end else if (md_xfer) begin
        issue  = 1'b1;
        bypass = 1'b1;
      end
      enq = md_xfer && !bypass;
    end

    if (deq) begin
      iss_addr = head_q.dest;
      iss_data = head_q.data;
      iss_r0   = (head_q.dest != 4'd0);
      head_d   = tail_q;
    end else if (bypass) begin
      iss_addr = md_dest;
      iss_data = md_result;
      iss_r0   = (md_dest != 4'd0);
    end

    // New entry lands behind whatever remains after this cycle's dequeue.
    if (enq) begin
      if (state_q == StOne && !deq) tail_d = md_entry;
      else                          head_d = md_entry;
    end

    unique case (state_q)
      StEmpty: if (enq) state_d = StOne;
      StOne: begin
        if (enq && !deq)      state_d = StFull;
        else if (deq && !enq) state_d = StEmpty;
      end
      StFull:  if (deq) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      we_q    <= 1'b0;
      r0_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      we_q    <= issue;
      r0_q    <= issue && iss_r0;
      if (issue) begin
        waddr_q <= iss_addr;
        wdata_q <= iss_data;
      end
    end
  end

  assign write_en      = we_q;
  assign R0_en         = r0_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: inputs change 1ns after each rising edge, outputs are
// checked 1ns later (combinational) or 1ns after the following edge (registered).
module tb_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst, halt_sys, alu_valid, md_valid;
  logic [3:0]  alu_dest, md_dest;
  logic [15:0] alu_result;
  logic [31:0] md_result;
  logic        alu_stall, md_ready, write_en, R0_en;
  logic [3:0]  write_address;
  logic [31:0] write_data;
  logic [1:0]  buf_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .halt_sys      (halt_sys),
    .alu_valid     (alu_valid),
    .alu_dest      (alu_dest),
    .alu_result    (alu_result),
    .alu_stall     (alu_stall),
    .md_valid      (md_valid),
    .md_ready      (md_ready),
    .md_dest       (md_dest),
    .md_result     (md_result),
    .write_en      (write_en),
    .R0_en         (R0_en),
    .write_address (write_address),
    .write_data    (write_data),
    .buf_count     (buf_count)
  );

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    md_valid  = 1'b0;
  endtask

  task automatic alu(input logic [3:0] d, input logic [15:0] r);
    alu_valid = 1'b1; alu_dest = d; alu_result = r;
  endtask

  task automatic md(input logic [3:0] d, input logic [31:0] r);
    md_valid = 1'b1; md_dest = d; md_result = r;
  endtask

  task automatic expect_write(input string tag, input logic [3:0] a, input logic [31:0] d,
                              input logic r0, input logic [1:0] bc);
    check({tag, ".we"},   36'(write_en), 36'd1);
    check({tag, ".addr"}, 36'(write_address), 36'(a));
    check({tag, ".data"}, 36'(write_data), 36'(d));
    check({tag, ".r0"},   36'(R0_en), 36'(r0));
    check({tag, ".buf"},  36'(buf_count), 36'(bc));
  endtask

  initial begin
    rst = 1'b1; halt_sys = 1'b0;
    alu_valid = 1'b1; alu_dest = 4'd9; alu_result = 16'hFFFF;
    md_valid = 1'b1; md_dest = 4'd9; md_result = 32'hFFFF_FFFF;
    #1;
    check("rst.md_ready", 36'(md_ready), 36'd0);
    check("rst.alu_stall", 36'(alu_stall), 36'd1);
    step(); step();
    check("rst.we", 36'(write_en), 36'd0);
    check("rst.r0", 36'(R0_en), 36'd0);
    check("rst.addr", 36'(write_address), 36'd0);
    check("rst.data", 36'(write_data), 36'd0);
    check("rst.buf", 36'(buf_count), 36'd0);
    rst = 1'b0; idle();
    step();

    // Single ALU write, then strobe drops while address/data hold
    alu(4'd3, 16'h1234);
    #1;
    check("alu.stall", 36'(alu_stall), 36'd0);
    check("alu.md_ready", 36'(md_ready), 36'd1);
    step();
    expect_write("alu", 4'd3, 32'h0000_1234, 1'b0, 2'd0);
    idle();
    step();
    check("alu.we_off", 36'(write_en), 36'd0);
    check("alu.data_hold", 36'(write_data), 36'h0_0000_1234);

    // md bypass when empty, plus the md_dest==0 R0 case
    md(4'd5, 32'hDEAD_BEEF);
    step();
    expect_write("byp", 4'd5, 32'hDEAD_BEEF, 1'b1, 2'd0);
    md(4'd0, 32'hAAAA_5555);
    step();
    expect_write("byp0", 4'd0, 32'hAAAA_5555, 1'b0, 2'd0);

    // ALU priority fills the FIFO; order 1,2,7,8
    alu(4'd1, 16'h0011); md(4'd7, 32'h7777_0007);
    step();
    expect_write("ord1", 4'd1, 32'h0000_0011, 1'b0, 2'd1);
    alu(4'd2, 16'h0022); md(4'd8, 32'h8888_0008);
    #1;
    check("ord.ready_one", 36'(md_ready), 36'd1);
    step();
    expect_write("ord2", 4'd2, 32'h0000_0022, 1'b0, 2'd2);
    alu(4'd4, 16'h0044); md_valid = 1'b0;
    #1;
    check("ord.stall_full", 36'(alu_stall), 36'd1);
    check("ord.ready_full", 36'(md_ready), 36'd0);
    step();
    expect_write("ord7", 4'd7, 32'h7777_0007, 1'b1, 2'd1);
    idle();
    step();
    expect_write("ord8", 4'd8, 32'h8888_0008, 1'b1, 2'd0);

    // Simultaneous dequeue and enqueue in ONE keeps one entry
    alu(4'd3, 16'h0033); md(4'd13, 32'hD00D_000D);
    step();
    expect_write("swap.alu", 4'd3, 32'h0000_0033, 1'b0, 2'd1);
    alu_valid = 1'b0; md(4'd14, 32'hE00E_000E);
    step();
    expect_write("swap.d13", 4'd13, 32'hD00D_000D, 1'b1, 2'd1);
    idle();
    step();
    expect_write("swap.d14", 4'd14, 32'hE00E_000E, 1'b1, 2'd0);

    // Halt while full: nothing moves, then drains in order
    alu(4'd1, 16'h0101); md(4'd9, 32'h9999_0009);
    step();
    alu(4'd2, 16'h0202); md(4'd10, 32'hAAAA_000A);
    step();
    halt_sys = 1'b1; alu(4'd6, 16'h0606); md(4'd11, 32'h1111_0011);
    #1;
    check("halt.md_ready", 36'(md_ready), 36'd0);
    check("halt.alu_stall", 36'(alu_stall), 36'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt.we", 36'(write_en), 36'd0);
      check("halt.r0", 36'(R0_en), 36'd0);
      check("halt.buf", 36'(buf_count), 36'd2);
    end
    check("halt.data_hold", 36'(write_data), 36'h0_0000_0202);
    halt_sys = 1'b0; idle();
    step();
    expect_write("halt.d9", 4'd9, 32'h9999_0009, 1'b1, 2'd1);
    step();
    expect_write("halt.d10", 4'd10, 32'hAAAA_000A, 1'b1, 2'd0);
    step();
    check("halt.done_we", 36'(write_en), 36'd0);

    // Reset discards buffered entries
    alu(4'd1, 16'h0001); md(4'd11, 32'hBBBB_000B);
    step();
    alu(4'd2, 16'h0002); md(4'd12, 32'hCCCC_000C);
    step();
    check("rstf.buf_full", 36'(buf_count), 36'd2);
    rst = 1'b1; halt_sys = 1'b1; idle();
    step();
    check("rstf.buf", 36'(buf_count), 36'd0);
    check("rstf.we", 36'(write_en), 36'd0);
    check("rstf.addr", 36'(write_address), 36'd0);
    check("rstf.data", 36'(write_data), 36'd0);
    rst = 1'b0; halt_sys = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rstf.no_write", 36'(write_en), 36'd0);
      check("rstf.buf_empty", 36'(buf_count), 36'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
